// File: rtl/arbitro_rr_pkg.sv
// Shared constants and FSM encoding for the transmit-side round-robin arbiter.
package arbitro_rr_pkg;

    localparam int unsigned N_FIFOS = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArb   = 2'd1,
        StPausa = 2'd2
    } estado_e;

endpackage

// File: rtl/arbitro_rr_prioridad.sv
// Circular priority search: first non-empty FIFO after last_grant, one-hot plus index.
module rr_prioridad
    import arbitro_rr_pkg::*;
(
    input  logic [N_FIFOS-1:0] empty,
    input  logic [SEL_W-1:0]   last_grant,
    input  logic               en,
    output logic [N_FIFOS-1:0] grant,
    output logic [SEL_W-1:0]   idx
);

    logic             found;
    logic [SEL_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // Offsets 1..N_FIFOS; the 2-bit add wraps 3+1 to 0 and ends on last_grant itself.
        for (int k = 1; k <= N_FIFOS; k++) begin
            cand = last_grant + SEL_W'(k);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (en && found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin drain of four input FIFOs into one output path; selector is aligned
// with the one-cycle FIFO read latency.
module arbitro_rr
    import arbitro_rr_pkg::*;
(
    input  logic               clk,
    input  logic               reset_L,
    input  logic [N_FIFOS-1:0] empty,
    input  logic               almost_full,
    output logic [N_FIFOS-1:0] pop,
    output logic               push,
    output logic [SEL_W-1:0]   selector,
    output logic               idle
);

    estado_e          state_q;
    logic [SEL_W-1:0] last_grant_q;
    logic [SEL_W-1:0] selector_q;
    logic             push_q;
    logic             arb_en;
    logic [SEL_W-1:0] g;

    // almost_full gates pop combinationally so no new word leaves once it rises.
    assign arb_en = (state_q == StArb) && !almost_full;

    rr_prioridad u_rr_prioridad (
        .empty      (empty),
        .last_grant (last_grant_q),
        .en         (arb_en),
        .grant      (pop),
        .idx        (g)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= StIdle;
            last_grant_q <= SEL_W'(N_FIFOS - 1);
            selector_q   <= '0;
            push_q       <= 1'b0;
        end else begin
            push_q <= |pop;
            if (|pop) begin
                selector_q   <= g;
                last_grant_q <= g;
            end
            case (state_q)
                StIdle: begin
                    if (!(&empty)) begin
                        state_q <= almost_full ? StPausa : StArb;
                    end
                end
                StArb: begin
                    if (almost_full) begin
                        state_q <= StPausa;
                    end else if (&empty) begin
                        state_q <= StIdle;
                    end
                end
                StPausa: begin
                    if (!almost_full) begin
                        state_q <= (&empty) ? StIdle : StArb;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign push     = push_q;
    assign selector = selector_q;
    assign idle     = (state_q == StIdle);

endmodule
